// File: rtl/kamacore_pkg.sv
// Shared kamacore constants: default datapath widths and register file port limits.
package kamacore_pkg;

   // Default machine word width and register address width.
   localparam int KC_CPU_WIDTH      = 32;
   localparam int KC_REG_ADDR_WIDTH = 5;

   // Supported ranges for the register file port counts.
   localparam int KC_MIN_READ  = 1;
   localparam int KC_MAX_READ  = 4;
   localparam int KC_MIN_WRITE = 1;
   localparam int KC_MAX_WRITE = 2;

endpackage : kamacore_pkg

// File: rtl/kamacore_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per register plus a registered
// population count of those bits.
module kamacore_scoreboard
   import kamacore_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = KC_REG_ADDR_WIDTH,
   parameter int NUM_WRITE      = 1,
   parameter int ZERO_REG       = 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_WRITE-1:0]                     rd_we,
   input  logic [NUM_WRITE-1:0][REG_ADDR_WIDTH-1:0] rd_a,
   input  logic                                     rsv_we,
   input  logic [REG_ADDR_WIDTH-1:0]                rsv_a,
   input  logic                                     flush,
   output logic [(2**REG_ADDR_WIDTH)-1:0]           busy_o,
   output logic [REG_ADDR_WIDTH:0]                  busy_count_o
);

   localparam int NREGS = 2**REG_ADDR_WIDTH;

   logic [NREGS-1:0]        busy_q, busy_d;
   logic [NREGS-1:0]        setMask, clrMask;
   logic [REG_ADDR_WIDTH:0] count_q, count_d;

   // Next busy state: a reservation beats a completing write on the same
   // register (the new producer owns it), and flush beats everything.
   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (rsv_we && !(ZERO_REG != 0 && rsv_a == '0)) begin
         setMask[rsv_a] = 1'b1;
      end
      for (int w = 0; w < NUM_WRITE; w++) begin
         if (rd_we[w]) begin
            clrMask[rd_a[w]] = 1'b1;
         end
      end
      if (flush) begin
         busy_d = '0;
      end else begin
         busy_d = (busy_q & ~clrMask) | setMask;
      end
   end

   // The counter is loaded with the population of the next busy vector so it
   // can never drift from the bits themselves.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         count_d = count_d + {{REG_ADDR_WIDTH{1'b0}}, busy_d[i]};
      end
   end

   // Busy bits and count update together on every edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_o       = busy_q;
   assign busy_count_o = count_q;

endmodule : kamacore_scoreboard

// File: rtl/kamacore_regfile_mp.sv
// Multi-ported register file with optional hardwired zero register, optional
// write-to-read forwarding and a busy-bit scoreboard for issue tracking.
module kamacore_regfile_mp
   import kamacore_pkg::*;
#(
   parameter int CPU_WIDTH      = KC_CPU_WIDTH,
   parameter int REG_ADDR_WIDTH = KC_REG_ADDR_WIDTH,
   parameter int NUM_READ       = 2,
   parameter int NUM_WRITE      = 1,
   parameter int ZERO_REG       = 1,
   parameter int BYPASS         = 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_READ-1:0][REG_ADDR_WIDTH-1:0]  rs_a,
   output logic [NUM_READ-1:0][CPU_WIDTH-1:0]       rs_data,
   output logic [NUM_READ-1:0]                      rs_busy,
   input  logic [NUM_WRITE-1:0]                     rd_we,
   input  logic [NUM_WRITE-1:0][REG_ADDR_WIDTH-1:0] rd_a,
   input  logic [NUM_WRITE-1:0][CPU_WIDTH-1:0]      rd_data,
   input  logic                                     rsv_we,
   input  logic [REG_ADDR_WIDTH-1:0]                rsv_a,
   input  logic                                     flush,
   output logic [REG_ADDR_WIDTH:0]                  busy_count
);

   localparam int NREGS = 2**REG_ADDR_WIDTH;

   // Port counts outside the supported range are rejected at elaboration.
   if (NUM_READ < KC_MIN_READ || NUM_READ > KC_MAX_READ) begin : g_bad_num_read
      $error("kamacore_regfile_mp: NUM_READ out of range");
   end
   if (NUM_WRITE < KC_MIN_WRITE || NUM_WRITE > KC_MAX_WRITE) begin : g_bad_num_write
      $error("kamacore_regfile_mp: NUM_WRITE out of range");
   end

   logic [CPU_WIDTH-1:0] regs_q [NREGS];
   logic [NREGS-1:0]     busyVec;

   kamacore_scoreboard #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .NUM_WRITE     (NUM_WRITE),
      .ZERO_REG      (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .rd_we       (rd_we),
      .rd_a        (rd_a),
      .rsv_we      (rsv_we),
      .rsv_a       (rsv_a),
      .flush       (flush),
      .busy_o      (busyVec),
      .busy_count_o(busy_count)
   );

   // Register storage; later write ports are applied last so the highest
   // index wins when two ports target the same register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (rd_we[w] && !(ZERO_REG != 0 && rd_a[w] == '0)) begin
               regs_q[rd_a[w]] <= rd_data[w];
            end
         end
      end
   end

   // Combinational read ports: stored value, overridden by the highest
   // matching write port when forwarding is enabled, and forced to zero for
   // the hardwired register. A forwarded read is no longer busy.
   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      for (int r = 0; r < NUM_READ; r++) begin
         rs_data[r] = regs_q[rs_a[r]];
         rs_busy[r] = busyVec[rs_a[r]];
         if (BYPASS != 0) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
               if (rd_we[w] && rd_a[w] == rs_a[r]) begin
                  rs_data[r] = rd_data[w];
                  rs_busy[r] = 1'b0;
               end
            end
         end
         if (ZERO_REG != 0 && rs_a[r] == '0) begin
            rs_data[r] = '0;
            rs_busy[r] = 1'b0;
         end
      end
   end

endmodule : kamacore_regfile_mp

// File: tb/tb_kamacore_regfile_mp.sv
// Directed testbench for kamacore_regfile_mp: a forwarding dual-write instance
// and a non-forwarding single-write instance share the same stimulus.
module tb_kamacore_regfile_mp;

   logic             clk;
   logic             rst;
   logic [1:0][4:0]  rs_a;
   logic [1:0][31:0] rs_data;
   logic [1:0]       rs_busy;
   logic [1:0]       rd_we;
   logic [1:0][4:0]  rd_a;
   logic [1:0][31:0] rd_data;
   logic             rsv_we;
   logic [4:0]       rsv_a;
   logic             flush;
   logic [5:0]       busy_count;

   logic [1:0][31:0] nbRsData;
   logic [1:0]       nbRsBusy;
   logic [5:0]       nbBusyCount;

   integer tests;
   integer fails;

   kamacore_regfile_mp #(
      .NUM_READ (2),
      .NUM_WRITE(2),
      .ZERO_REG (1),
      .BYPASS   (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rs_a      (rs_a),
      .rs_data   (rs_data),
      .rs_busy   (rs_busy),
      .rd_we     (rd_we),
      .rd_a      (rd_a),
      .rd_data   (rd_data),
      .rsv_we    (rsv_we),
      .rsv_a     (rsv_a),
      .flush     (flush),
      .busy_count(busy_count)
   );

   kamacore_regfile_mp #(
      .NUM_READ (2),
      .NUM_WRITE(1),
      .ZERO_REG (1),
      .BYPASS   (0)
   ) dut_nb (
      .clk       (clk),
      .rst       (rst),
      .rs_a      (rs_a),
      .rs_data   (nbRsData),
      .rs_busy   (nbRsBusy),
      .rd_we     (rd_we[0:0]),
      .rd_a      (rd_a[0:0]),
      .rd_data   (rd_data[0:0]),
      .rsv_we    (rsv_we),
      .rsv_a     (rsv_a),
      .flush     (flush),
      .busy_count(nbBusyCount)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clear_inputs();
      rd_we   = '0;
      rd_a    = '0;
      rd_data = '0;
      rsv_we  = 1'b0;
      rsv_a   = '0;
      flush   = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      rs_a = '0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b1;
      rs_a = {5'd7, 5'd5};
      #1;
      tests++;
      if (busy_count !== 6'd0) begin
         fails++;
         $display("[TB] FAIL reset_count: got %0d expected 0", busy_count);
      end
      tests++;
      if (rs_data !== 64'd0) begin
         fails++;
         $display("[TB] FAIL reset_data: got %h expected 0", rs_data);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      rd_we      = 2'b01;
      rd_a[0]    = 5'd5;
      rd_data[0] = 32'hDEADBEEF;
      rs_a       = {5'd7, 5'd5};
      #1;
      tests++;
      if (rs_data[0] !== 32'hDEADBEEF) begin
         fails++;
         $display("[TB] FAIL bypass_x5: got %h expected deadbeef", rs_data[0]);
      end
      tests++;
      if (nbRsData[0] !== 32'h0) begin
         fails++;
         $display("[TB] FAIL nobypass_x5: got %h expected 0", nbRsData[0]);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (rs_data[0] !== 32'hDEADBEEF || nbRsData[0] !== 32'hDEADBEEF) begin
         fails++;
         $display("[TB] FAIL stored_x5: got %h/%h expected deadbeef", rs_data[0], nbRsData[0]);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      rd_we      = 2'b01;
      rd_a[0]    = 5'd0;
      rd_data[0] = 32'h1234;
      rsv_we     = 1'b1;
      rsv_a      = 5'd0;
      rs_a       = {5'd0, 5'd0};
      #1;
      tests++;
      if (rs_data[0] !== 32'h0) begin
         fails++;
         $display("[TB] FAIL x0_bypass: got %h expected 0", rs_data[0]);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (rs_data[0] !== 32'h0 || nbRsData[0] !== 32'h0) begin
         fails++;
         $display("[TB] FAIL x0_stored: got %h/%h expected 0", rs_data[0], nbRsData[0]);
      end
      tests++;
      if (busy_count !== 6'd0 || rs_busy !== 2'b00) begin
         fails++;
         $display("[TB] FAIL x0_rsv: got count %0d busy %b expected 0/00", busy_count, rs_busy);
      end
   endtask

   task automatic test_dual_write();
      @(negedge clk);
      rd_we   = 2'b11;
      rd_a    = {5'd7, 5'd7};
      rd_data = {32'hB, 32'hA};
      rs_a    = {5'd7, 5'd5};
      #1;
      tests++;
      if (rs_data[1] !== 32'hB) begin
         fails++;
         $display("[TB] FAIL dual_bypass: got %h expected b", rs_data[1]);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (rs_data[1] !== 32'hB) begin
         fails++;
         $display("[TB] FAIL dual_stored: got %h expected b", rs_data[1]);
      end
      tests++;
      if (nbRsData[1] !== 32'hA) begin
         fails++;
         $display("[TB] FAIL single_port_x7: got %h expected a", nbRsData[1]);
      end
   endtask

   task automatic test_reservation();
      @(negedge clk);
      rsv_we = 1'b1;
      rsv_a  = 5'd3;
      rs_a   = {5'd5, 5'd3};
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (rs_busy !== 2'b01 || busy_count !== 6'd1) begin
         fails++;
         $display("[TB] FAIL rsv_x3: got busy %b count %0d expected 01/1", rs_busy, busy_count);
      end
      @(negedge clk);
      rd_we      = 2'b01;
      rd_a[0]    = 5'd3;
      rd_data[0] = 32'h55;
      rsv_we     = 1'b1;
      rsv_a      = 5'd3;
      #1;
      tests++;
      if (rs_busy[0] !== 1'b0 || rs_data[0] !== 32'h55) begin
         fails++;
         $display("[TB] FAIL rsv_fwd: got busy %b data %h expected 0/55", rs_busy[0], rs_data[0]);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (rs_busy[0] !== 1'b1 || busy_count !== 6'd1 || nbBusyCount !== 6'd1) begin
         fails++;
         $display("[TB] FAIL set_beats_clear: got busy %b count %0d/%0d expected 1/1/1", rs_busy[0], busy_count, nbBusyCount);
      end
      @(negedge clk);
      rd_we      = 2'b01;
      rd_a[0]    = 5'd3;
      rd_data[0] = 32'h55;
      #1;
      tests++;
      if (nbRsBusy[0] !== 1'b1) begin
         fails++;
         $display("[TB] FAIL nobypass_busy: got %b expected 1", nbRsBusy[0]);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (rs_busy[0] !== 1'b0 || busy_count !== 6'd0 || nbBusyCount !== 6'd0) begin
         fails++;
         $display("[TB] FAIL write_clears: got busy %b count %0d/%0d expected 0/0/0", rs_busy[0], busy_count, nbBusyCount);
      end
   endtask

   task automatic test_flush();
      logic [4:0] rsvList [3];
      rsvList[0] = 5'd1;
      rsvList[1] = 5'd2;
      rsvList[2] = 5'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rsv_we = 1'b1;
         rsv_a  = rsvList[i];
      end
      @(negedge clk);
      clear_inputs();
      rs_a = {5'd2, 5'd1};
      #1;
      tests++;
      if (busy_count !== 6'd3 || rs_busy !== 2'b11) begin
         fails++;
         $display("[TB] FAIL three_rsv: got count %0d busy %b expected 3/11", busy_count, rs_busy);
      end
      @(negedge clk);
      flush  = 1'b1;
      rsv_we = 1'b1;
      rsv_a  = 5'd6;
      @(negedge clk);
      clear_inputs();
      rs_a = {5'd2, 5'd6};
      #1;
      tests++;
      if (busy_count !== 6'd0 || rs_busy !== 2'b00) begin
         fails++;
         $display("[TB] FAIL flush: got count %0d busy %b expected 0/00", busy_count, rs_busy);
      end
      rs_a = {5'd3, 5'd5};
      #1;
      tests++;
      if (rs_data[0] !== 32'hDEADBEEF || rs_data[1] !== 32'h55) begin
         fails++;
         $display("[TB] FAIL flush_data: got %h/%h expected deadbeef/55", rs_data[0], rs_data[1]);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      rsv_we = 1'b1;
      rsv_a  = 5'd9;
      @(negedge clk);
      clear_inputs();
      rs_a = {5'd7, 5'd5};
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if (rs_data !== 64'd0) begin
         fails++;
         $display("[TB] FAIL async_data: got %h expected 0", rs_data);
      end
      tests++;
      if (busy_count !== 6'd0 || nbBusyCount !== 6'd0) begin
         fails++;
         $display("[TB] FAIL async_count: got %0d/%0d expected 0/0", busy_count, nbBusyCount);
      end
      @(negedge clk);
      rd_we      = 2'b01;
      rd_a[0]    = 5'd5;
      rd_data[0] = 32'hFFFF;
      rsv_we     = 1'b1;
      rsv_a      = 5'd9;
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      #1;
      tests++;
      if (rs_data[0] !== 32'h0 || busy_count !== 6'd0) begin
         fails++;
         $display("[TB] FAIL reset_ignores: got %h count %0d expected 0/0", rs_data[0], busy_count);
      end
      rd_we      = 2'b01;
      rd_a[0]    = 5'd5;
      rd_data[0] = 32'h77;
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (rs_data[0] !== 32'h77 || nbRsData[0] !== 32'h77) begin
         fails++;
         $display("[TB] FAIL resume: got %h/%h expected 77", rs_data[0], nbRsData[0]);
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_write_read();
      test_zero_reg();
      test_dual_write();
      test_reservation();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_kamacore_regfile_mp
